// File: rtl/mux_cmd_master.sv
// rtl/mux_cmd_master.sv - console-mux command initiator: request -> uart_tx bytes, uart_rx readback -> response
module mux_cmd_master #(
  parameter int OUTPUT_COUNT   = 16,
  parameter int INPUT_COUNT    = 4,
  parameter int SEL_WIDTH      = $clog2(INPUT_COUNT) * OUTPUT_COUNT,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [OUTPUT_COUNT-1:0] req_mask,
  input  logic [SEL_WIDTH-1:0]    req_map,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_status,
  output logic [OUTPUT_COUNT-1:0] rsp_mask,
  output logic [SEL_WIDTH-1:0]    rsp_map,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_done,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data
);

  localparam int MASK_BYTES = OUTPUT_COUNT / 8;
  localparam int MAP_BYTES  = SEL_WIDTH / 8;
  localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND  = 3'd1;
  localparam logic [2:0] ST_GUARD = 3'd2;
  localparam logic [2:0] ST_RECV  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] STS_OK       = 2'd0;
  localparam logic [1:0] STS_MISMATCH = 2'd1;
  localparam logic [1:0] STS_TIMEOUT  = 2'd2;
  localparam logic [1:0] STS_BAD_OP   = 2'd3;

  logic [2:0]              state;
  logic [2:0]              lat_op;
  logic [OUTPUT_COUNT-1:0] lat_mask;
  logic [SEL_WIDTH-1:0]    lat_map;
  logic [7:0]              tx_cnt;
  logic [7:0]              rx_cnt;
  logic [TW-1:0]           to_cnt;

  logic                    is_write;
  logic                    is_mask;
  logic [7:0]              len;
  logic [7:0]              total;
  logic                    tx_last;
  logic                    armed;
  logic                    rx_take;
  logic [7:0]              rx_cnt_nxt;
  logic [7:0]              pidx;
  logic [7:0]              cur_byte;
  logic [OUTPUT_COUNT-1:0] mask_nxt;
  logic [SEL_WIDTH-1:0]    map_nxt;
  logic                    mismatch;

  assign is_write = (lat_op == 3'd3) || (lat_op == 3'd4);
  assign is_mask  = (lat_op == 3'd1) || (lat_op == 3'd3);
  assign len      = is_mask ? 8'(MASK_BYTES) : 8'(MAP_BYTES);
  assign total    = is_write ? len + 8'd1 : 8'd1;
  assign tx_last  = (tx_cnt == total - 8'd1);

  // Capture opens on the cycle the final command byte is launched, so an
  // early responder overlapping the transmit tail is not lost.
  assign armed = ((state == ST_SEND) && tx_done && tx_last) ||
                 ((state == ST_GUARD) && (tx_cnt == total)) ||
                 (state == ST_RECV);
  assign rx_take    = rx_valid && armed && (rx_cnt < len);
  assign rx_cnt_nxt = rx_cnt + {7'd0, rx_take};

  assign tx_start  = (state == ST_SEND) && tx_done;
  assign tx_data   = (state == ST_SEND) ? cur_byte : 8'hFF;
  assign rsp_valid = (state == ST_DONE);
  assign req_ready = (state == ST_IDLE);

  always_comb begin
    pidx     = tx_cnt - 8'd1;
    cur_byte = {5'b0, lat_op};
    if (tx_cnt != 8'd0) begin
      cur_byte = 8'h00;
      for (int k = 0; k < MASK_BYTES; k++)
        if (is_mask && pidx == 8'(k)) cur_byte = lat_mask[8*k +: 8];
      for (int k = 0; k < MAP_BYTES; k++)
        if (!is_mask && pidx == 8'(k)) cur_byte = lat_map[8*k +: 8];
    end
  end

  // Response fields including the byte arriving this cycle, so completion
  // status can be decided on the same edge the last byte lands.
  always_comb begin
    mask_nxt = rsp_mask;
    map_nxt  = rsp_map;
    if (rx_take) begin
      for (int k = 0; k < MASK_BYTES; k++)
        if (is_mask && rx_cnt == 8'(k)) mask_nxt[8*k +: 8] = rx_data;
      for (int k = 0; k < MAP_BYTES; k++)
        if (!is_mask && rx_cnt == 8'(k)) map_nxt[8*k +: 8] = rx_data;
    end
    mismatch = is_write && (is_mask ? (mask_nxt != lat_mask) : (map_nxt != lat_map));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_op     <= 3'd0;
      lat_mask   <= '0;
      lat_map    <= '0;
      tx_cnt     <= 8'd0;
      rx_cnt     <= 8'd0;
      to_cnt     <= '0;
      rsp_status <= STS_OK;
      rsp_mask   <= '0;
      rsp_map    <= '0;
    end else begin
      rsp_mask <= mask_nxt;
      rsp_map  <= map_nxt;
      rx_cnt   <= rx_cnt_nxt;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_op   <= req_op;
            lat_mask <= req_mask;
            lat_map  <= req_map;
            rsp_mask <= '0;
            rsp_map  <= '0;
            tx_cnt   <= 8'd0;
            rx_cnt   <= 8'd0;
            to_cnt   <= '0;
            if (req_op >= 3'd1 && req_op <= 3'd4) begin
              state <= ST_SEND;
            end else begin
              rsp_status <= STS_BAD_OP;
              state      <= ST_DONE;
            end
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            tx_cnt <= tx_cnt + 8'd1;
            state  <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (tx_cnt == total) begin
            to_cnt <= '0;
            state  <= ST_RECV;
          end else begin
            state <= ST_SEND;
          end
        end
        ST_RECV: begin
          if (rx_cnt_nxt == len) begin
            rsp_status <= mismatch ? STS_MISMATCH : STS_OK;
            state      <= ST_DONE;
          end else if (rx_take) begin
            to_cnt <= '0;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_status <= STS_TIMEOUT;
            state      <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_cmd_master.sv
// tb/tb_mux_cmd_master.sv - directed vector bench for mux_cmd_master with a lagging transmitter model
module tb_mux_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_mask;
  logic [31:0] req_map;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_mask;
  logic [31:0] rsp_map;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        rx_valid;
  logic [7:0]  rx_data;

  mux_cmd_master #(
    .OUTPUT_COUNT(16), .INPUT_COUNT(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_mask(req_mask), .req_map(req_map),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_mask(rsp_mask), .rsp_map(rsp_map),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: tx_done falls one cycle late after tx_start, stays low a few cycles.
  logic [7:0] tx_q[$];
  int         busy = 0;
  logic       done_pend = 1'b1;
  initial tx_done = 1'b1;
  always @(negedge clk) begin
    tx_done = done_pend;
    done_pend = (busy == 0);
    if (tx_start) begin
      tx_q.push_back(tx_data);
      busy = 6;
    end else if (busy != 0) begin
      busy = busy - 1;
    end
  end

  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  logic [1:0]  got_st;
  logic [15:0] got_mask;
  logic [31:0] got_map;
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt = rsp_cnt + 1;
      rsp_cyc = cyc;
      got_st = rsp_status;
      got_mask = rsp_mask;
      got_map = rsp_map;
    end
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int last_rx_cyc = 0;
  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle_tx(input int budget);
    for (int i = 0; i < budget && !(tx_done && done_pend && busy == 0); i++) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] mask;
    logic [31:0] map;
    int          n_rx;
    logic [31:0] rx;
    int          n_tx;
    logic [39:0] tx;
    logic [1:0]  st;
    logic [15:0] emask;
    logic [31:0] emap;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    int acc_cyc;
    string tag;
    tag = $sformatf("v%0d", idx);
    idle_tx(50);
    @(negedge clk);
    tx_q.delete();
    rsp_cnt = 0;
    req_valid = 1'b1;
    req_op = v.op;
    req_mask = v.mask;
    req_map = v.map;
    chk({tag, "_ready"}, 40'(req_ready), 40'd1);
    @(negedge clk);
    req_valid = 1'b0;
    acc_cyc = cyc;
    chk({tag, "_ready_drop"}, 40'(req_ready), 40'd0);
    if (v.n_tx > 0) begin
      for (int i = 0; i < 500 && tx_q.size() < v.n_tx; i++) @(negedge clk);
      chk({tag, "_tx_wait"}, 40'(tx_q.size()), 40'(v.n_tx));
    end
    for (int j = 0; j < v.n_rx; j++) send_rx(v.rx[8*j +: 8]);
    for (int i = 0; i < 400 && rsp_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_rsp_cnt"}, 40'(rsp_cnt), 40'd1);
    chk({tag, "_status"}, 40'(got_st), 40'(v.st));
    chk({tag, "_mask"}, 40'(got_mask), 40'(v.emask));
    chk({tag, "_map"}, 40'(got_map), 40'(v.emap));
    chk({tag, "_tx_n"}, 40'(tx_q.size()), 40'(v.n_tx));
    for (int j = 0; j < v.n_tx && j < tx_q.size(); j++)
      chk($sformatf("%s_tx%0d", tag, j), 40'(tx_q[j]), 40'(v.tx[8*j +: 8]));
    if (v.st == 2'd3)
      chk({tag, "_badop_lat"}, 40'((rsp_cyc - acc_cyc) <= 3), 40'd1);
    if (v.st == 2'd2 && v.n_rx > 0)
      chk({tag, "_timeout_lat"}, 40'(rsp_cyc - last_rx_cyc), 40'd101);
    chk({tag, "_hold_mask"}, 40'(rsp_mask), 40'(v.emask));
    chk({tag, "_hold_map"}, 40'(rsp_map), 40'(v.emap));
  endtask

  initial begin
    vecs[0] = '{3'd1, 16'h0000, 32'h0, 2, 32'h0000_1234, 1, 40'h01, 2'd0, 16'h1234, 32'h0};
    vecs[1] = '{3'd4, 16'h0000, 32'hA1B2C3D4, 4, 32'hA1B2C3D4, 5, 40'hA1B2C3D404, 2'd0, 16'h0, 32'hA1B2C3D4};
    vecs[2] = '{3'd4, 16'h0000, 32'hA1B2C3D4, 4, 32'hA0B2C3D4, 5, 40'hA1B2C3D404, 2'd1, 16'h0, 32'hA0B2C3D4};
    vecs[3] = '{3'd3, 16'hBEEF, 32'h0, 2, 32'h0000_BEEF, 3, 40'hBEEF03, 2'd0, 16'hBEEF, 32'h0};
    vecs[4] = '{3'd2, 16'h0000, 32'h0, 4, 32'h1234_5678, 1, 40'h02, 2'd0, 16'h0, 32'h1234_5678};
    vecs[5] = '{3'd2, 16'h0000, 32'h0, 2, 32'h0000_2211, 1, 40'h02, 2'd2, 16'h0, 32'h0000_2211};
    vecs[6] = '{3'd7, 16'hFFFF, 32'hFFFFFFFF, 0, 32'h0, 0, 40'h0, 2'd3, 16'h0, 32'h0};
    vecs[7] = '{3'd3, 16'h1234, 32'h0, 2, 32'h0000_1334, 3, 40'h123403, 2'd1, 16'h1334, 32'h0};
    vecs[8] = '{3'd0, 16'hFFFF, 32'h0, 0, 32'h0, 0, 40'h0, 2'd3, 16'h0, 32'h0};
    vecs[9] = '{3'd1, 16'h0000, 32'h0, 0, 32'h0, 1, 40'h01, 2'd2, 16'h0, 32'h0};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_mask = 16'h0;
    req_map = 32'h0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 40'(req_ready), 40'd1);
    chk("rst_tx_start", 40'(tx_start), 40'd0);
    chk("rst_tx_data", 40'(tx_data), 40'hFF);
    chk("rst_rsp_valid", 40'(rsp_valid), 40'd0);
    chk("rst_rsp_status", 40'(rsp_status), 40'd0);
    chk("rst_rsp_mask", 40'(rsp_mask), 40'd0);
    chk("rst_rsp_map", 40'(rsp_map), 40'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Abort an op 3 while its second payload byte is on the wire.
    idle_tx(50);
    @(negedge clk);
    tx_q.delete();
    rsp_cnt = 0;
    req_valid = 1'b1;
    req_op = 3'd3;
    req_mask = 16'h5AA5;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 200 && tx_q.size() < 3; i++) @(negedge clk);
    chk("abort_tx_wait", 40'(tx_q.size()), 40'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rsp_mask", 40'(rsp_mask), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 40'(req_ready), 40'd1);
    chk("abort_tx_data", 40'(tx_data), 40'hFF);
    send_rx(8'hEE);
    send_rx(8'hDD);
    repeat (20) @(negedge clk);
    chk("abort_no_rsp", 40'(rsp_cnt), 40'd0);
    chk("abort_tx_n", 40'(tx_q.size()), 40'd3);
    chk("stray_ignored", 40'(rsp_mask), 40'd0);
    run_vec(vecs[0], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mux_cmd_master.md
Name: mux_cmd_master

Overview:
- Host-side initiator for the console-mux serial command protocol.
- Takes one request at a time from a local request port and serializes it into command and payload bytes on a uart_tx byte interface.
- Collects the responder's readback bytes from a uart_rx byte interface and returns them with a status code.
- Used by the bench driver and by a future board-to-board mux controller that configures a remote comm instance.

Parameters:
- OUTPUT_COUNT, 16, number of mux outputs; must be a multiple of 8.
- INPUT_COUNT, 4, number of mux inputs.
- SEL_WIDTH, $clog2(INPUT_COUNT)*OUTPUT_COUNT, pin-map width; must be a multiple of 8 (derived, not overridden).
- TIMEOUT_CYCLES, 65535, maximum number of clk cycles allowed between response bytes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master idle and able to accept a request
- req_op  in  3  1=READ_ENABLE_MASK, 2=READ_PIN_MAP, 3=WRITE_ENABLE_MASK, 4=WRITE_PIN_MAP
- req_mask  in  OUTPUT_COUNT  enable mask payload for op 3
- req_map  in  SEL_WIDTH  pin-map payload for op 4
- rsp_valid  out  1  one-cycle pulse: response fields valid
- rsp_status  out  2  0=OK, 1=MISMATCH, 2=TIMEOUT, 3=BAD_OP
- rsp_mask  out  OUTPUT_COUNT  received enable mask (ops 1, 3)
- rsp_map  out  SEL_WIDTH  received pin map (ops 2, 4)
- tx_data  out  8  byte to uart_tx
- tx_start  out  1  one-cycle pulse: load tx_data into the transmitter
- tx_done  in  1  transmitter idle (level)
- rx_valid  in  1  one-cycle pulse: rx_data holds a new byte
- rx_data  in  8  received byte

Behaviour:
- Reset values:
  - req_ready=1; rsp_valid=0, rsp_status=0, rsp_mask=0, rsp_map=0.
  - tx_data=8'hFF, tx_start=0.
  - State=IDLE, all counters 0.
- Reset asserted mid-operation aborts immediately. No rsp_valid is issued for the aborted request.
- Byte lengths:
  - MASK_BYTES = OUTPUT_COUNT/8.
  - MAP_BYTES = SEL_WIDTH/8.
  - LEN(op) is MASK_BYTES for ops 1 and 3, MAP_BYTES for ops 2 and 4.
- Byte order: byte k occupies bits [8k+7:8k] and is sent or received with k=0 first (LSB byte first), for both tx payload and rx response.
- Request accept:
  - A request is accepted in the cycle where req_valid && req_ready.
  - op, mask and map are latched in that cycle; req_ready drops in the next cycle.
- BAD_OP: if the latched op is not 1..4, go straight to DONE with status 3. No bytes are transmitted.
- State machine:
  - IDLE: req_ready=1. rx bytes are discarded.
  - SEND: if tx_done=1 and no guard is pending, drive tx_data and pulse tx_start for one cycle. The first byte is {5'b0, op}; it is followed by LEN payload bytes for ops 3 and 4 only. Go to GUARD.
  - GUARD: one cycle, tx_done ignored (the transmitter may lag one cycle in dropping tx_done). Then go to SEND if bytes remain, otherwise to RECV.
  - RECV: on each rx_valid, store rx_data into byte slot rx_cnt and increment rx_cnt. When rx_cnt reaches LEN, go to DONE.
  - DONE: pulse rsp_valid for one cycle, then go to IDLE with req_ready=1 in the following cycle.
- RX arming:
  - rx capture is armed from the cycle the final tx_start pulses, so a response that overlaps the tail of transmission is not lost.
  - rx_valid before arming is discarded.
  - rx_valid after RECV completes (stray bytes) is discarded in DONE and IDLE.
- Timeout:
  - Counter cleared on entry to RECV and on each rx_valid.
  - When it reaches TIMEOUT_CYCLES, go to DONE with status 2.
  - rsp fields hold the partial bytes received; unreceived bytes are 0.
- Status:
  - Ops 3 and 4: status 1 if the received readback differs from the latched payload, else 0.
  - Ops 1 and 2: status 0 on completion.
- rsp_mask and rsp_map are cleared at request accept and hold their value after rsp_valid until the next accept.
- Simultaneous events: when rx_valid and the timeout-expiry cycle coincide, the byte is taken and the counter clears, so no timeout occurs.
- Total command bytes are 1 (read ops) or 1+LEN (write ops). Transmission never starts while tx_done=0.

Test Plan:
- Reset: pulse rst_n low for 3 cycles -> req_ready=1, tx_start=0, tx_data=8'hFF, rsp_valid=0.
- Op 1: model responds 8'h34 then 8'h12 -> exactly one tx byte 8'h01; rsp_valid once with rsp_mask=16'h1234, status=0.
- Op 4 with req_map=32'hA1B2C3D4: model echoes D4, C3, B2, A1 -> tx bytes 04, D4, C3, B2, A1 in that order; rsp_map=32'hA1B2C3D4, status=0. Repeat with the echo's last byte as A0 -> status=1.
- Op 2 with the model returning only 2 bytes, TIMEOUT_CYCLES=100 -> rsp_valid 100 cycles after the last byte; status=2, rsp_map low 16 bits = received bytes, upper 16 bits = 0.
- req_op=7 -> no tx_start pulses; rsp_valid with status=3 within 3 cycles of accept.
- Assert rst_n low during the second payload byte of op 3 -> no rsp_valid, req_ready=1 after release. A new op 1 request then completes normally, and stray rx bytes injected while idle are ignored.
